mem_stage_lsu: RTL and testbench

- MEM-stage consumer of the EXE/MEM pipeline register outputs.
- Issues loads and stores to data memory over a req/ack handshake, with byte/half/word lanes and load sign/zero extension.
- Resolves branches from the registered zero flag and redirects the PC.
- Stalls the upstream pipeline while an access is outstanding and presents registered results to the MEM/WB register.

---
 rtl/mem_stage_lsu.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit and branch resolver.
//   Consumes the EXE/MEM pipeline register, issues byte/half/word accesses
//   to data memory over a req/ack handshake, and stalls upstream while an
//   access is outstanding. It presents registered writeback results to
//   MEM/WB and resolves branches, producing a PC redirect.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   pc_mem, offset_i           PC in MEM and branch/jump offset
//   registerWriteEnable_i      instruction writes rd
//   dataWriteEnable_i          store
//   regSelect_i                load (rd takes memory data)
//   memSize_i                  funct3 access size / signedness
//   branchCtr_i, zero_i        branch kind and ALU zero flag
//   dataB_i, aluOut_i          store data, effective address / ALU result
//   dmem_*                     data-memory request/response interface
//   stall_o                    freeze upstream stages (combinational)
//   branch_taken_o/_target_o   PC redirect (combinational)
//   wb_regWrite_o, wb_data_o   registered writeback to MEM/WB
//   misalign_err_o, timeout_err_o  one-cycle error pulses
module mem_stage_lsu #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_mem,
    input  logic              registerWriteEnable_i,
    input  logic              dataWriteEnable_i,
    input  logic              regSelect_i,
    input  logic [2:0]        memSize_i,
    input  logic [1:0]        branchCtr_i,
    input  logic [DATA_W-1:0] dataB_i,
    input  logic [ADDR_W-1:0] offset_i,
    input  logic [DATA_W-1:0] aluOut_i,
    input  logic              zero_i,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_o,
    output logic              branch_taken_o,
    output logic [ADDR_W-1:0] branch_target_o,
    output logic              wb_regWrite_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              misalign_err_o,
    output logic              timeout_err_o
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;

    // Access attributes captured at issue; the inputs may move once stall drops.
    logic [2:0]        cap_size, cap_size_n;
    logic [1:0]        cap_lane, cap_lane_n;
    logic              cap_rwe, cap_rwe_n;
    logic              cap_store, cap_store_n;

    logic              req_n, we_n;
    logic [DATA_W-1:0] addr_n, wdata_n;
    logic [3:0]        be_n;
    logic              wb_we_n;
    logic [DATA_W-1:0] wb_data_n;
    logic              mis_n, to_n;

    logic              access;
    logic              misalign;
    logic              timed_out;
    logic              br_cond;
    logic [1:0]        lane;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] load_ext;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    assign access    = regSelect_i | dataWriteEnable_i;
    assign lane      = aluOut_i[1:0];
    assign timed_out = (cnt == CNT_W'(TIMEOUT));

    // Lane decode, store replication and alignment check for the presented access.
    always_comb begin
        be_c     = 4'b1111;
        wdata_c  = dataB_i;
        misalign = 1'b0;
        unique case (memSize_i[1:0])
            2'b00: begin
                be_c    = 4'(4'b0001 << lane);
                wdata_c = {4{dataB_i[7:0]}};
            end
            2'b01: begin
                be_c     = lane[1] ? 4'b1100 : 4'b0011;
                wdata_c  = {2{dataB_i[15:0]}};
                misalign = access & lane[0];
            end
            default: begin
                misalign = access & (lane != 2'b00);
            end
        endcase
    end

    // Load lane extraction with sign/zero extension, from the captured access.
    always_comb begin
        rd_byte  = dmem_rdata[{cap_lane, 3'b000} +: 8];
        rd_half  = cap_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_ext = dmem_rdata;
        unique case (cap_size[1:0])
            2'b00:   load_ext = {{(DATA_W-8){~cap_size[2] & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{(DATA_W-16){~cap_size[2] & rd_half[15]}}, rd_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    // Stall and branch resolution; a branch only fires in an unstalled IDLE cycle.
    always_comb begin
        stall_o = ((state == IDLE) & access & ~misalign) |
                  ((state == WAIT) & ~dmem_ack & ~timed_out);
        unique case (branchCtr_i)
            2'b01:   br_cond = zero_i;
            2'b10:   br_cond = ~zero_i;
            2'b11:   br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
        branch_taken_o  = br_cond & ~stall_o & (state == IDLE);
        branch_target_o = pc_mem + offset_i;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cap_size_n  = cap_size;
        cap_lane_n  = cap_lane;
        cap_rwe_n   = cap_rwe;
        cap_store_n = cap_store;
        req_n       = dmem_req;
        we_n        = dmem_we;
        addr_n      = dmem_addr;
        be_n        = dmem_be;
        wdata_n     = dmem_wdata;
        wb_we_n     = 1'b0;
        wb_data_n   = wb_data_o;
        mis_n       = 1'b0;
        to_n        = 1'b0;

        unique case (state)
            IDLE: begin
                if (access && misalign) begin
                    mis_n = 1'b1;
                end else if (access) begin
                    state_n     = WAIT;
                    cnt_n       = '0;
                    req_n       = 1'b1;
                    we_n        = dataWriteEnable_i;
                    addr_n      = {aluOut_i[DATA_W-1:2], 2'b00};
                    be_n        = be_c;
                    wdata_n     = wdata_c;
                    cap_size_n  = memSize_i;
                    cap_lane_n  = lane;
                    cap_rwe_n   = registerWriteEnable_i;
                    cap_store_n = dataWriteEnable_i;
                end else begin
                    wb_data_n = aluOut_i;
                    wb_we_n   = registerWriteEnable_i;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_n   = IDLE;
                    req_n     = 1'b0;
                    wb_data_n = load_ext;
                    wb_we_n   = cap_rwe & ~cap_store;
                end else if (timed_out) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    to_n    = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            cap_size       <= '0;
            cap_lane       <= '0;
            cap_rwe        <= 1'b0;
            cap_store      <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_be        <= '0;
            dmem_wdata     <= '0;
            wb_regWrite_o  <= 1'b0;
            wb_data_o      <= '0;
            misalign_err_o <= 1'b0;
            timeout_err_o  <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            cap_size       <= cap_size_n;
            cap_lane       <= cap_lane_n;
            cap_rwe        <= cap_rwe_n;
            cap_store      <= cap_store_n;
            dmem_req       <= req_n;
            dmem_we        <= we_n;
            dmem_addr      <= addr_n;
            dmem_be        <= be_n;
            dmem_wdata     <= wdata_n;
            wb_regWrite_o  <= wb_we_n;
            wb_data_o      <= wb_data_n;
            misalign_err_o <= mis_n;
            timeout_err_o  <= to_n;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_mem;
    logic        registerWriteEnable_i;
    logic        dataWriteEnable_i;
    logic        regSelect_i;
    logic [2:0]  memSize_i;
    logic [1:0]  branchCtr_i;
    logic [31:0] dataB_i;
    logic [31:0] offset_i;
    logic [31:0] aluOut_i;
    logic        zero_i;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_o;
    logic        branch_taken_o;
    logic [31:0] branch_target_o;
    logic        wb_regWrite_o;
    logic [31:0] wb_data_o;
    logic        misalign_err_o;
    logic        timeout_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;
    int req_cnt;

    logic        obs_we;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;

    mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .pc_mem                (pc_mem),
        .registerWriteEnable_i (registerWriteEnable_i),
        .dataWriteEnable_i     (dataWriteEnable_i),
        .regSelect_i           (regSelect_i),
        .memSize_i             (memSize_i),
        .branchCtr_i           (branchCtr_i),
        .dataB_i               (dataB_i),
        .offset_i              (offset_i),
        .aluOut_i              (aluOut_i),
        .zero_i                (zero_i),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_be               (dmem_be),
        .dmem_wdata            (dmem_wdata),
        .dmem_ack              (dmem_ack),
        .dmem_rdata            (dmem_rdata),
        .stall_o               (stall_o),
        .branch_taken_o        (branch_taken_o),
        .branch_target_o       (branch_target_o),
        .wb_regWrite_o         (wb_regWrite_o),
        .wb_data_o             (wb_data_o),
        .misalign_err_o        (misalign_err_o),
        .timeout_err_o         (timeout_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        registerWriteEnable_i = 1'b0;
        dataWriteEnable_i     = 1'b0;
        regSelect_i           = 1'b0;
        memSize_i             = 3'b010;
        branchCtr_i           = 2'b00;
        dataB_i               = '0;
        offset_i              = '0;
        aluOut_i              = '0;
        zero_i                = 1'b0;
        pc_mem                = '0;
    endtask

    task automatic set_mem(input logic load, input logic store, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] data);
        set_idle();
        regSelect_i           = load;
        dataWriteEnable_i     = store;
        registerWriteEnable_i = load;
        memSize_i             = size;
        aluOut_i              = addr;
        dataB_i               = data;
    endtask

    // Runs an access already presented on the inputs; ack arrives after ack_delay WAIT cycles.
    task automatic run_access(input int ack_delay, input logic [31:0] rdata);
        stall_cnt = 0;
        #1;
        if (stall_o) stall_cnt++;
        tick();
        obs_we    = dmem_we;
        obs_addr  = dmem_addr;
        obs_be    = dmem_be;
        obs_wdata = dmem_wdata;
        for (int i = 0; i < ack_delay; i++) begin
            if (stall_o) stall_cnt++;
            tick();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        #1;
        if (stall_o) stall_cnt++;
        tick();
        dmem_ack = 1'b0;
        set_idle();
    endtask

    initial begin
        rst        = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        set_idle();
        #12;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_wb_we", 32'(wb_regWrite_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        rst = 1'b1;
        tick();

        // ALU op without memory access: latency-1 writeback
        set_idle();
        registerWriteEnable_i = 1'b1;
        aluOut_i = 32'h0000_1234;
        #1;
        check("alu_stall", 32'(stall_o), 32'd0);
        tick();
        check("alu_wb_data", wb_data_o, 32'h0000_1234);
        check("alu_wb_we", 32'(wb_regWrite_o), 32'd1);
        set_idle();

        // SW 0x104, ack after 2 WAIT cycles
        set_mem(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
        run_access(2, 32'h0);
        check("sw_we", 32'(obs_we), 32'd1);
        check("sw_addr", obs_addr, 32'h0000_0104);
        check("sw_be", 32'(obs_be), 32'hF);
        check("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
        check("sw_stall_cycles", 32'(stall_cnt), 32'd3);
        check("sw_wb_we", 32'(wb_regWrite_o), 32'd0);
        check("sw_req_drop", 32'(dmem_req), 32'd0);

        // LB 0x103, immediate ack
        set_mem(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
        run_access(0, 32'h80FF_0000);
        check("lb_be", 32'(obs_be), 32'h8);
        check("lb_addr", obs_addr, 32'h0000_0100);
        check("lb_data", wb_data_o, 32'hFFFF_FF80);
        check("lb_wb_we", 32'(wb_regWrite_o), 32'd1);
        check("lb_stall_cycles", 32'(stall_cnt), 32'd1);

        // LBU 0x103
        set_mem(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
        run_access(0, 32'h80FF_0000);
        check("lbu_data", wb_data_o, 32'h0000_0080);

        // LH 0x102
        set_mem(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0);
        run_access(1, 32'h80FF_0000);
        check("lh_be", 32'(obs_be), 32'hC);
        check("lh_data", wb_data_o, 32'hFFFF_80FF);

        // LHU 0x100
        set_mem(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0);
        run_access(0, 32'h1234_8001);
        check("lhu_data", wb_data_o, 32'h0000_8001);

        // SB 0x101
        set_mem(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB);
        run_access(0, 32'h0);
        check("sb_be", 32'(obs_be), 32'h2);
        check("sb_wdata", obs_wdata, 32'hABAB_ABAB);

        // SH 0x106
        set_mem(1'b0, 1'b1, 3'b001, 32'h0000_0106, 32'h0000_C0DE);
        run_access(0, 32'h0);
        check("sh_be", 32'(obs_be), 32'hC);
        check("sh_wdata", obs_wdata, 32'hC0DE_C0DE);

        // LW 0x102: misaligned
        set_mem(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0);
        #1;
        check("mis_stall", 32'(stall_o), 32'd0);
        tick();
        check("mis_pulse", 32'(misalign_err_o), 32'd1);
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_wb_we", 32'(wb_regWrite_o), 32'd0);
        set_idle();
        tick();
        check("mis_pulse_end", 32'(misalign_err_o), 32'd0);

        // LW 0x200, ack withheld: timeout
        set_mem(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
        tick();
        req_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (timeout_err_o) break;
            if (dmem_req) req_cnt++;
            tick();
        end
        check("to_pulse", 32'(timeout_err_o), 32'd1);
        check("to_req_cycles", 32'(req_cnt), 32'd16);
        check("to_req_drop", 32'(dmem_req), 32'd0);
        check("to_wb_we", 32'(wb_regWrite_o), 32'd0);
        set_idle();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h5555_5555;
        #1;
        check("late_ack_stall", 32'(stall_o), 32'd0);
        tick();
        dmem_ack = 1'b0;
        check("late_ack_wb_we", 32'(wb_regWrite_o), 32'd0);
        check("late_ack_req", 32'(dmem_req), 32'd0);
        check("to_pulse_end", 32'(timeout_err_o), 32'd0);

        // Branches
        set_idle();
        pc_mem = 32'h40; offset_i = 32'hFFFF_FFF0; branchCtr_i = 2'b01; zero_i = 1'b1;
        #1;
        check("beq_taken", 32'(branch_taken_o), 32'd1);
        check("beq_target", branch_target_o, 32'h30);
        branchCtr_i = 2'b10;
        #1;
        check("bne_z1", 32'(branch_taken_o), 32'd0);
        zero_i = 1'b0;
        #1;
        check("bne_z0", 32'(branch_taken_o), 32'd1);
        branchCtr_i = 2'b01;
        #1;
        check("beq_z0", 32'(branch_taken_o), 32'd0);
        branchCtr_i = 2'b11;
        pc_mem = 32'hFFFF_FFF8; offset_i = 32'h10;
        #1;
        check("jal_taken", 32'(branch_taken_o), 32'd1);
        check("jal_wrap", branch_target_o, 32'h8);

        // Branch suppressed while stalled; reset asserted in WAIT
        set_mem(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        branchCtr_i = 2'b11;
        #1;
        check("br_stalled", 32'(branch_taken_o), 32'd0);
        tick();
        check("wait_req", 32'(dmem_req), 32'd1);
        check("br_in_wait", 32'(branch_taken_o), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_req", 32'(dmem_req), 32'd0);
        check("rst_async_addr", dmem_addr, 32'd0);
        check("rst_async_be", 32'(dmem_be), 32'd0);
        check("rst_async_wb", wb_data_o, 32'd0);
        set_idle();
        #1;
        check("rst_idle_stall", 32'(stall_o), 32'd0);
        tick();
        rst = 1'b1;
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("post_rst_req", 32'(dmem_req), 32'd0);
        check("post_rst_wb_we", 32'(wb_regWrite_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
